// File: rtl/booth_mac_accumulator.sv
// booth_mac_accumulator
//   Sums a programmed block of signed 16-bit products from the radix-4
//   Booth/Wallace 8x8 multiplier and presents one ACC_W-bit result per block
//   over a valid/ready handshake.
//   Optional feature: define SATURATE_EN to clamp overflowing adds to the
//   signed ACC_W range instead of wrapping. acc_ovf reports overflow in both
//   builds.
module booth_mac_accumulator #(
    parameter int ACC_W = 24,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             prod_valid,
    input  logic [15:0]      prod,
    output logic             prod_ready,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic [ACC_W-1:0] acc_sum,
    output logic             acc_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};

`ifdef SATURATE_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Clamp value chosen by the common sign of the two addends.
    function automatic logic [ACC_W-1:0] clamp_value(input logic neg);
        if (neg) begin
            clamp_value = ACC_MIN;
        end else begin
            clamp_value = ACC_MAX;
        end
    endfunction
`endif

    // Sign-extend a 16-bit product to the accumulator width.
    function automatic logic [ACC_W-1:0] sext_prod(input logic [15:0] p);
        logic [ACC_W-1:0] r;
        r       = {ACC_W{p[15]}};
        r[15:0] = p;
        return r;
    endfunction

    // Two's-complement overflow: addends agree in sign, sum does not.
    function automatic logic add_overflows(input logic [ACC_W-1:0] a,
                                           input logic [ACC_W-1:0] b,
                                           input logic [ACC_W-1:0] s);
        return (a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]);
    endfunction

    state_t           state_r;
    logic [ACC_W-1:0] acc_r;
    logic [LEN_W-1:0] count_r;
    logic             ovf_r;
    logic             prod_ready_r;
    logic             acc_valid_r;
    logic             busy_r;

    logic [ACC_W-1:0] prod_ext_s;
    logic [ACC_W-1:0] sum_raw_s;
    logic             add_ovf_s;
    logic [ACC_W-1:0] acc_next_s;
    logic             accept_s;
    logic             last_s;

    // Accumulator datapath: extended product, raw sum, overflow and next value.
    always_comb begin
        prod_ext_s = sext_prod(prod);
        sum_raw_s  = acc_r + prod_ext_s;
        add_ovf_s  = add_overflows(acc_r, prod_ext_s, sum_raw_s);
        acc_next_s = sum_raw_s;
`ifdef SATURATE_EN
        if (add_ovf_s) begin
            acc_next_s = clamp_value(acc_r[ACC_W-1]);
        end else begin
            acc_next_s = sum_raw_s;
        end
`endif
        // prod_ready_r is high only in ACCUM, so it doubles as the state qualifier.
        accept_s = prod_valid && prod_ready_r;
        if (count_r == LEN_ONE) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
    end

    // Block-control FSM with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            acc_r        <= ACC_ZERO;
            count_r      <= LEN_ZERO;
            ovf_r        <= 1'b0;
            prod_ready_r <= 1'b0;
            acc_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        count_r <= cfg_len;
                        acc_r   <= ACC_ZERO;
                        ovf_r   <= 1'b0;
                        busy_r  <= 1'b1;
                        if (cfg_len != LEN_ZERO) begin
                            state_r      <= ST_ACCUM;
                            prod_ready_r <= 1'b1;
                        end else begin
                            // Empty block: report a zero sum straight away.
                            state_r     <= ST_HOLD;
                            acc_valid_r <= 1'b1;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (accept_s) begin
                        acc_r   <= acc_next_s;
                        ovf_r   <= ovf_r | add_ovf_s;
                        count_r <= count_r - LEN_ONE;
                        if (last_s) begin
                            state_r      <= ST_HOLD;
                            prod_ready_r <= 1'b0;
                            acc_valid_r  <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    // Result and flag stay frozen until the consumer takes them;
                    // start is not looked at here.
                    if (acc_ready) begin
                        state_r     <= ST_IDLE;
                        acc_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    prod_ready_r <= 1'b0;
                    acc_valid_r  <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign prod_ready = prod_ready_r;
    assign acc_valid  = acc_valid_r;
    assign acc_sum    = acc_r;
    assign acc_ovf    = ovf_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_booth_mac_accumulator.sv
// tb_booth_mac_accumulator
//   Directed, table-driven bench for booth_mac_accumulator. A 24-bit instance
//   covers block accumulation, stalls, empty blocks, reset and HOLD behaviour;
//   a 16-bit instance covers wrap / saturation (SATURATE_EN aware).
module tb_booth_mac_accumulator;

`ifdef SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    logic        start, prod_valid, acc_ready;
    logic [7:0]  cfg_len;
    logic [15:0] prod;
    logic        prod_ready, acc_valid, acc_ovf, busy;
    logic [23:0] acc_sum;

    logic        start16, prod_valid16, acc_ready16;
    logic [7:0]  cfg_len16;
    logic [15:0] prod16;
    logic        prod_ready16, acc_valid16, acc_ovf16, busy16;
    logic [15:0] acc_sum16;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int               len;
        logic [7:0][15:0] p;
        logic [7:0]       gap;
        longint           exp_sum;
        logic             exp_ovf;
    } vec_t;

    vec_t vecs[7];

    booth_mac_accumulator #(.ACC_W(24), .LEN_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
        .prod_valid(prod_valid), .prod(prod), .prod_ready(prod_ready),
        .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_sum(acc_sum),
        .acc_ovf(acc_ovf), .busy(busy)
    );

    booth_mac_accumulator #(.ACC_W(16), .LEN_W(8)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .cfg_len(cfg_len16),
        .prod_valid(prod_valid16), .prod(prod16), .prod_ready(prod_ready16),
        .acc_valid(acc_valid16), .acc_ready(acc_ready16), .acc_sum(acc_sum16),
        .acc_ovf(acc_ovf16), .busy(busy16)
    );

    // 100 MHz free-running clock.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Run one block on the 24-bit instance: start, feed products with optional
    // one-cycle gaps, verify latency, result, then hand the result off.
    task automatic run_block(input int vi, input vec_t v);
        int idx;
        int cyc;
        bit gap_done;
        start   = 1'b1;
        cfg_len = v.len[7:0];
        prod_valid = 1'b0;
        tick();
        start = 1'b0;
        check($sformatf("v%0d busy after start", vi), longint'(busy), 1);
        if (v.len == 0) begin
            check($sformatf("v%0d empty prod_ready", vi), longint'(prod_ready), 0);
            check($sformatf("v%0d empty acc_valid", vi), longint'(acc_valid), 1);
        end else begin
            idx = 0;
            cyc = 0;
            gap_done = 1'b0;
            while (idx < v.len && cyc < 100) begin
                check($sformatf("v%0d prod_ready in block", vi), longint'(prod_ready), 1);
                check($sformatf("v%0d acc_valid early", vi), longint'(acc_valid), 0);
                if (v.gap[idx] && !gap_done) begin
                    prod_valid = 1'b0;
                    gap_done = 1'b1;
                end else begin
                    prod_valid = 1'b1;
                    prod = v.p[idx];
                end
                tick();
                cyc++;
                if (prod_valid) begin
                    idx++;
                    gap_done = 1'b0;
                end
            end
            prod_valid = 1'b0;
            check($sformatf("v%0d accept budget", vi), longint'(idx), longint'(v.len));
            check($sformatf("v%0d acc_valid latency", vi), longint'(acc_valid), 1);
        end
        check($sformatf("v%0d acc_sum", vi), longint'($signed(acc_sum)), v.exp_sum);
        check($sformatf("v%0d acc_ovf", vi), longint'(acc_ovf), longint'(v.exp_ovf));
        check($sformatf("v%0d prod_ready in hold", vi), longint'(prod_ready), 0);
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
        check($sformatf("v%0d acc_valid after take", vi), longint'(acc_valid), 0);
        check($sformatf("v%0d busy after take", vi), longint'(busy), 0);
    endtask

    // Run one back-to-back block on the 16-bit instance.
    task automatic run16(input string name, input int len, input logic [2:0][15:0] p,
                         input longint exp_sum, input logic exp_ovf);
        start16 = 1'b1;
        cfg_len16 = len[7:0];
        tick();
        start16 = 1'b0;
        for (int i = 0; i < len; i++) begin
            check({name, " ready"}, longint'(prod_ready16), 1);
            prod_valid16 = 1'b1;
            prod16 = p[i];
            tick();
        end
        prod_valid16 = 1'b0;
        check({name, " valid"}, longint'(acc_valid16), 1);
        check({name, " sum"}, longint'($signed(acc_sum16)), exp_sum);
        check({name, " ovf"}, longint'(acc_ovf16), longint'(exp_ovf));
        acc_ready16 = 1'b1;
        tick();
        acc_ready16 = 1'b0;
        check({name, " released"}, longint'(acc_valid16), 0);
    endtask

    initial begin
        for (int i = 0; i < 7; i++) begin
            vecs[i].p = '0;
            vecs[i].gap = 8'd0;
            vecs[i].exp_ovf = 1'b0;
        end
        vecs[0].len = 2; vecs[0].p[0] = 16'd10; vecs[0].p[1] = 16'd20;
        vecs[0].exp_sum = 30;
        vecs[1].len = 4; vecs[1].p[0] = 16'd100; vecs[1].p[1] = 16'hFFCE;
        vecs[1].p[2] = 16'h4000; vecs[1].p[3] = 16'hC000; vecs[1].gap = 8'b0000_0101;
        vecs[1].exp_sum = 50;
        vecs[2].len = 3; vecs[2].p[0] = 16'hFFFF; vecs[2].p[1] = 16'hFFFF;
        vecs[2].p[2] = 16'hFFFF; vecs[2].exp_sum = -3;
        vecs[3].len = 1; vecs[3].p[0] = 16'h7FFF; vecs[3].exp_sum = 32767;
        vecs[4].len = 8;
        for (int j = 0; j < 8; j++) vecs[4].p[j] = 16'h8000;
        vecs[4].gap = 8'b1000_0001; vecs[4].exp_sum = -262144;
        vecs[5].len = 5;
        for (int j = 0; j < 5; j++) vecs[5].p[j] = 16'(j + 1);
        vecs[5].gap = 8'b0001_0010; vecs[5].exp_sum = 15;
        vecs[6].len = 0; vecs[6].exp_sum = 0;

        rst = 1'b1;
        start = 1'b0; cfg_len = 8'd0; prod_valid = 1'b0; prod = 16'd0; acc_ready = 1'b0;
        start16 = 1'b0; cfg_len16 = 8'd0; prod_valid16 = 1'b0; prod16 = 16'd0;
        acc_ready16 = 1'b0;
        tick();
        tick();
        check("reset prod_ready", longint'(prod_ready), 0);
        check("reset acc_valid", longint'(acc_valid), 0);
        check("reset acc_sum", longint'(acc_sum), 0);
        check("reset acc_ovf", longint'(acc_ovf), 0);
        check("reset busy", longint'(busy), 0);
        check("reset16 acc_sum", longint'(acc_sum16), 0);
        rst = 1'b0;
        tick();

        // Reset in the middle of a 5-product block after 3 accepts.
        start = 1'b1; cfg_len = 8'd5;
        tick();
        start = 1'b0;
        prod_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            prod = 16'(1000 * (i + 1));
            tick();
        end
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0; prod_valid = 1'b0;
        check("midrst acc_valid", longint'(acc_valid), 0);
        check("midrst busy", longint'(busy), 0);
        check("midrst acc_sum", longint'(acc_sum), 0);
        check("midrst prod_ready", longint'(prod_ready), 0);
        tick();
        check("midrst stays idle", longint'(busy), 0);

        for (int i = 0; i < 7; i++) begin
            run_block(i, vecs[i]);
        end

        // Long block: 255 products of 16384.
        start = 1'b1; cfg_len = 8'd255;
        tick();
        start = 1'b0;
        for (int i = 0; i < 255; i++) begin
            check("long prod_ready", longint'(prod_ready), 1);
            prod_valid = 1'b1;
            prod = 16'h4000;
            tick();
        end
        prod_valid = 1'b0;
        check("long acc_valid", longint'(acc_valid), 1);
        check("long acc_sum", longint'($signed(acc_sum)), 4177920);
        check("long acc_ovf", longint'(acc_ovf), 0);
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;

        // HOLD stability: consumer stalls while products and starts keep coming.
        start = 1'b1; cfg_len = 8'd1;
        tick();
        start = 1'b0;
        prod_valid = 1'b1; prod = 16'd7;
        tick();
        for (int k = 0; k < 10; k++) begin
            prod_valid = 1'b1;
            prod = 16'd999;
            start = k[0];
            acc_ready = 1'b0;
            tick();
            check("hold acc_valid", longint'(acc_valid), 1);
            check("hold acc_sum", longint'($signed(acc_sum)), 7);
            check("hold prod_ready", longint'(prod_ready), 0);
        end
        acc_ready = 1'b1; start = 1'b1;
        tick();
        acc_ready = 1'b0; start = 1'b0; prod_valid = 1'b0;
        check("hold release acc_valid", longint'(acc_valid), 0);
        check("hold release busy", longint'(busy), 0);
        tick();
        check("hold start ignored", longint'(prod_ready), 0);
        check("hold start ignored busy", longint'(busy), 0);

        // 16-bit accumulator: wrap or saturate.
        run16("w16 pos_ovf", 2, {16'd0, 16'd1, 16'h7FFF}, SAT ? 32767 : -32768, 1'b1);
        run16("w16 clear", 1, {16'd0, 16'd0, 16'd5}, 5, 1'b0);
        run16("w16 neg_ovf", 2, {16'd0, 16'hFFFF, 16'h8000}, SAT ? -32768 : 32767, 1'b1);
        run16("w16 continue", 3, {16'hFFF6, 16'd1, 16'h7FFF}, SAT ? 32757 : 32758, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
